// File: rtl/toggle_event_decoder.sv
// -----------------------------------------------------------------------------
// toggle_event_decoder
//
// Receive side of a toggle-encoded (T flip-flop) event link. The sender flips a
// single level line once per event. This block synchronises that line into
// clk, turns every level change into a one-cycle pulse, and keeps a saturating
// count of events the consumer has not yet taken.
//
// Parameters
//   SYNC_STAGES  synchroniser depth on tog_in (legal 2..4)
//   CNT_W        pending counter width; holds up to 2**CNT_W-1 events
//   INIT_LEVEL   reset level of the synchroniser and reference register; must
//                equal the sender's T-FF reset value
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-low reset
//   tog_in     in   toggle-encoded event line (asynchronous to clk)
//   evt_ready  in   consumer takes one buffered event this cycle
//   clr_ovf    in   clears the sticky overflow flag
//   evt_valid  out  at least one event buffered
//   evt_pulse  out  one-cycle pulse per detected toggle
//   pending    out  number of buffered, unaccepted events
//   overflow   out  sticky: an event was dropped because the buffer was full
//   tog_level  out  synchronised tog_in (last synchroniser stage)
//   dbg_state  out  buffer state: 0 EMPTY, 1 ACTIVE, 2 FULL
//
// Handshake: an event is handed over on every rising edge where evt_valid and
// evt_ready are both high; evt_valid is combinational from the pending count,
// and evt_ready is ignored while nothing is buffered.
// -----------------------------------------------------------------------------
module toggle_event_decoder #(
  parameter int   SYNC_STAGES = 2,
  parameter int   CNT_W       = 4,
  parameter logic INIT_LEVEL  = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tog_in,
  input  logic             evt_ready,
  input  logic             clr_ovf,
  output logic             evt_valid,
  output logic             evt_pulse,
  output logic [CNT_W-1:0] pending,
  output logic             overflow,
  output logic             tog_level,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    BUF_EMPTY  = 2'd0,
    BUF_ACTIVE = 2'd1,
    BUF_FULL   = 2'd2
  } buf_state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   edge_r;
  buf_state_t             buf_state;
  logic                   push;
  logic                   pop;

  // Synchroniser plus change detector. The chain and the reference both start
  // at INIT_LEVEL, so a line already away from INIT_LEVEL at reset release is
  // reported as exactly one event.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= {SYNC_STAGES{INIT_LEVEL}};
      prev_q <= INIT_LEVEL;
      edge_r <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], tog_in};
      prev_q <= sync_q[SYNC_STAGES-1];
      edge_r <= sync_q[SYNC_STAGES-1] ^ prev_q;
    end
  end

  assign tog_level = sync_q[SYNC_STAGES-1];
  assign evt_pulse = edge_r;

  // Buffer state is a pure function of the count; no separate state register.
  always_comb begin
    buf_state = BUF_ACTIVE;
    if (pending == '0) begin
      buf_state = BUF_EMPTY;
    end else if (pending == CNT_MAX) begin
      buf_state = BUF_FULL;
    end
  end

  assign evt_valid = (pending != '0);
  assign push      = edge_r;
  assign pop       = evt_valid & evt_ready;
  assign dbg_state = buf_state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending  <= '0;
      overflow <= 1'b0;
    end else begin
      case (buf_state)
        BUF_EMPTY: begin
          // pop cannot be high here, so a push always lands.
          if (push) pending <= pending + CNT_ONE;
        end
        BUF_ACTIVE: begin
          if (push && !pop) begin
            pending <= pending + CNT_ONE;
          end else if (pop && !push) begin
            pending <= pending - CNT_ONE;
          end
        end
        BUF_FULL: begin
          // A push without a simultaneous pop is dropped; count stays at max.
          if (pop && !push) pending <= pending - CNT_ONE;
        end
        default: pending <= pending;
      endcase

      // Setting takes priority over clearing in the same cycle.
      if (push && !pop && (buf_state == BUF_FULL)) begin
        overflow <= 1'b1;
      end else if (clr_ovf) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_toggle_event_decoder.sv
// -----------------------------------------------------------------------------
// Bench for toggle_event_decoder (SYNC_STAGES=2, CNT_W=4, INIT_LEVEL=0).
// The reference keeps the history of sampled tog_in values and a queue of
// buffered events; expected outputs are derived from that history directly.
// -----------------------------------------------------------------------------
module tb_toggle_event_decoder;

  localparam int   SYNC_STAGES = 2;
  localparam int   CNT_W       = 4;
  localparam logic INIT_LEVEL  = 1'b0;
  localparam int   MAX_EVT     = (1 << CNT_W) - 1;

  logic             clk;
  logic             reset;
  logic             tog_in;
  logic             evt_ready;
  logic             clr_ovf;
  logic             evt_valid;
  logic             evt_pulse;
  logic [CNT_W-1:0] pending;
  logic             overflow;
  logic             tog_level;
  logic [1:0]       dbg_state;

  int checks = 0;
  int errors = 0;
  int pulse_cnt = 0;

  toggle_event_decoder #(
    .SYNC_STAGES(SYNC_STAGES),
    .CNT_W      (CNT_W),
    .INIT_LEVEL (INIT_LEVEL)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .tog_in   (tog_in),
    .evt_ready(evt_ready),
    .clr_ovf  (clr_ovf),
    .evt_valid(evt_valid),
    .evt_pulse(evt_pulse),
    .pending  (pending),
    .overflow (overflow),
    .tog_level(tog_level),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

  // ---------------- reference model ----------------
  logic        hist[$] = '{INIT_LEVEL, INIT_LEVEL, INIT_LEVEL};
  logic [15:0] exp_q[$];
  logic [15:0] evt_seq = 16'd0;
  logic        exp_pulse = 1'b0;
  logic        exp_ovf = 1'b0;
  logic        exp_level = INIT_LEVEL;
  logic        m_push, m_pop, m_drop;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist      = '{INIT_LEVEL, INIT_LEVEL, INIT_LEVEL};
      exp_q.delete();
      exp_pulse = 1'b0;
      exp_ovf   = 1'b0;
      exp_level = INIT_LEVEL;
    end else begin
      // Event seen during the cycle just ending is offered to the buffer now.
      m_push = exp_pulse;
      m_pop  = (exp_q.size() != 0) && evt_ready;
      m_drop = 1'b0;
      if (m_pop) void'(exp_q.pop_front());
      if (m_push) begin
        if (exp_q.size() >= MAX_EVT) m_drop = 1'b1;
        else exp_q.push_back(evt_seq);
        evt_seq = evt_seq + 16'd1;
      end
      if (m_drop) exp_ovf = 1'b1;
      else if (clr_ovf) exp_ovf = 1'b0;
      // A change of tog_in between edges k-1 and k shows as a pulse after edge k+2.
      hist.push_back(tog_in);
      exp_pulse = hist[hist.size()-3] != hist[hist.size()-4];
      exp_level = hist[hist.size()-2];
      if (hist.size() > 8) void'(hist.pop_front());
    end
  end

  function automatic logic [1:0] exp_state(int n);
    if (n == 0) return 2'd0;
    if (n == MAX_EVT) return 2'd2;
    return 2'd1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard compare (every cycle, away from posedge) ----------------
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (evt_pulse === 1'b1) pulse_cnt++;
      check("evt_pulse", 32'(evt_pulse), 32'(exp_pulse));
      check("pending",   32'(pending),   32'(exp_q.size()));
      check("evt_valid", 32'(evt_valid), 32'(exp_q.size() != 0));
      check("overflow",  32'(overflow),  32'(exp_ovf));
      check("tog_level", 32'(tog_level), 32'(exp_level));
      check("dbg_state", 32'(dbg_state), 32'(exp_state(exp_q.size())));
    end
  end

  // ---------------- driver tasks ----------------
  // Returns 2 time units after a rising edge; inputs written afterwards are
  // sampled at the next rising edge.
  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic toggle_n(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      tog_in = ~tog_in;
      cyc(gap);
    end
  endtask

  task automatic drain();
    evt_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (exp_q.size() == 0 && exp_pulse == 1'b0) break;
      cyc();
    end
    evt_ready = 1'b0;
    cyc(4);
    check("drain_empty", 32'(pending), 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    cyc(3);
    reset = 1'b1;
    cyc(1);
  endtask

  int p0;
  int exp_seq[5] = '{2, 1, 0, 0, 0};

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b0;
    tog_in = INIT_LEVEL;
    evt_ready = 1'b0;
    clr_ovf = 1'b0;
    #1;
    check("reset_pending",  32'(pending),   32'd0);
    check("reset_valid",    32'(evt_valid), 32'd0);
    check("reset_pulse",    32'(evt_pulse), 32'd0);
    check("reset_overflow", 32'(overflow),  32'd0);
    check("reset_level",    32'(tog_level), 32'(INIT_LEVEL));
    cyc(3);
    reset = 1'b1;

    // 1: idle line after release
    p0 = pulse_cnt;
    cyc(20);
    check("idle_pulses",   32'(pulse_cnt - p0), 32'd0);
    check("idle_pending",  32'(pending),        32'd0);
    check("idle_overflow", 32'(overflow),       32'd0);

    // 2: single toggle latency, then one pop
    tog_in = 1'b1;           // sampled at edge n
    cyc(2);                  // after edges n, n+1
    check("lat_before", 32'(evt_pulse), 32'd0);
    cyc(1);                  // after edge n+2
    check("lat_pulse",  32'(evt_pulse), 32'd1);
    cyc(1);
    check("lat_after",  32'(evt_pulse), 32'd0);
    check("lat_pending", 32'(pending),  32'd1);
    check("lat_valid",  32'(evt_valid), 32'd1);
    evt_ready = 1'b1;
    cyc(1);
    evt_ready = 1'b0;
    check("pop_pending", 32'(pending),  32'd0);
    check("pop_valid",   32'(evt_valid), 32'd0);

    // 3: toggle every cycle for 8 cycles
    p0 = pulse_cnt;
    toggle_n(8, 1);
    cyc(5);
    check("burst_pulses",  32'(pulse_cnt - p0), 32'd8);
    check("burst_pending", 32'(pending),        32'd8);
    drain();

    // 4: fill to capacity, overflow, clear, push+pop at full
    toggle_n(15, 2);
    cyc(4);
    check("full_pending",  32'(pending),  32'd15);
    check("full_overflow", 32'(overflow), 32'd0);
    toggle_n(1, 1);
    cyc(5);
    check("ovf_pending",  32'(pending),  32'd15);
    check("ovf_set",      32'(overflow), 32'd1);
    clr_ovf = 1'b1;
    cyc(1);
    clr_ovf = 1'b0;
    check("ovf_clear", 32'(overflow), 32'd0);
    tog_in = ~tog_in;
    cyc(3);                  // pulse is high during this cycle
    check("fullpp_pulse", 32'(evt_pulse), 32'd1);
    evt_ready = 1'b1;
    cyc(1);
    evt_ready = 1'b0;
    check("fullpp_pending",  32'(pending),  32'd15);
    check("fullpp_overflow", 32'(overflow), 32'd0);
    drain();

    // 5: push+pop at 3, then pop down through empty
    toggle_n(3, 2);
    cyc(4);
    check("p3_pending", 32'(pending), 32'd3);
    tog_in = ~tog_in;
    cyc(3);
    evt_ready = 1'b1;
    cyc(1);
    evt_ready = 1'b0;
    check("p3pp_pending", 32'(pending), 32'd3);
    evt_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      check("pop_seq_pending", 32'(pending),   32'(exp_seq[i]));
      check("pop_seq_valid",   32'(evt_valid), 32'(exp_seq[i] != 0));
    end
    evt_ready = 1'b0;

    // 6: async reset between edges with tog_in=1, then one release event
    tog_in = 1'b0;
    do_reset();
    cyc(4);
    toggle_n(5, 2);          // 0 -> 1 after five flips
    cyc(4);
    check("pre_rst_pending", 32'(pending), 32'd5);
    check("pre_rst_tog",     32'(tog_in),  32'd1);
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    check("arst_pending",  32'(pending),   32'd0);
    check("arst_valid",    32'(evt_valid), 32'd0);
    check("arst_pulse",    32'(evt_pulse), 32'd0);
    check("arst_overflow", 32'(overflow),  32'd0);
    check("arst_level",    32'(tog_level), 32'd0);
    #3 reset = 1'b1;
    p0 = pulse_cnt;
    cyc(6);
    check("release_pulses",  32'(pulse_cnt - p0), 32'd1);
    check("release_pending", 32'(pending),        32'd1);
    drain();

    // 7: randomized traffic, first biased toward filling, then toward draining
    for (int i = 0; i < 1200; i++) begin
      if ($urandom_range(0, 99) < 40) tog_in = ~tog_in;
      evt_ready = ($urandom_range(0, 99) < ((i < 600) ? 8 : 45));
      clr_ovf   = ($urandom_range(0, 99) < 5);
      cyc(1);
    end
    evt_ready = 1'b0;
    clr_ovf = 1'b0;
    cyc(4);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
